// File: rtl/arbiter_pkg.sv
// Shared definitions for the core memory arbiter:
// FSM state encoding and requester IDs.
package arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: bit 0 = fetch, bit 1 = data.
// On a tie the side that did not win last time is granted.
module rr_arbiter2
  import arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (req == 2'b11): grant = (last == REQ_I) ? 2'b10 : 2'b01;
      (req == 2'b10): grant = 2'b10;
      (req == 2'b01): grant = 2'b01;
      default:        grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Fetch/data arbiter in front of a single shared memory port,
// one transaction outstanding at a time.
module core_mem_arbiter
  import arbiter_pkg::*;
#(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_req_valid,
  input  logic [ADDRESS_BITS-1:0] i_req_addr,
  output logic                    i_req_ready,
  output logic                    i_resp_valid,
  output logic [DATA_WIDTH-1:0]   i_resp_data,
  input  logic                    d_req_valid,
  input  logic                    d_req_write,
  input  logic [ADDRESS_BITS-1:0] d_req_addr,
  input  logic [DATA_WIDTH-1:0]   d_req_data,
  output logic                    d_req_ready,
  output logic                    d_resp_valid,
  output logic [DATA_WIDTH-1:0]   d_resp_data,
  output logic                    mem_valid,
  output logic                    mem_write,
  output logic [ADDRESS_BITS-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_data,
  input  logic                    mem_ready,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_resp_data,
  input  logic                    report
);

  state_t      state;
  logic        last;
  logic        owner;
  logic [1:0]  grant;
  logic        can_grant;
  logic [31:0] i_grants;
  logic [31:0] d_grants;
  logic [31:0] conflict_cycles;
  logic [31:0] spurious;

  rr_arbiter2 u_rr (
    .req   ({d_req_valid, i_req_valid}),
    .last  (last),
    .grant (grant)
  );

  assign can_grant   = (state == IDLE) && !reset;
  assign i_req_ready = can_grant && grant[0];
  assign d_req_ready = can_grant && grant[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      last            <= REQ_I;
      owner           <= REQ_I;
      mem_valid       <= 1'b0;
      mem_write       <= 1'b0;
      mem_addr        <= '0;
      mem_data        <= '0;
      i_resp_valid    <= 1'b0;
      i_resp_data     <= '0;
      d_resp_valid    <= 1'b0;
      d_resp_data     <= '0;
      i_grants        <= '0;
      d_grants        <= '0;
      conflict_cycles <= '0;
      spurious        <= '0;
    end else begin
      i_resp_valid <= 1'b0;
      d_resp_valid <= 1'b0;
      if (state == IDLE && i_req_valid && d_req_valid)
        conflict_cycles <= conflict_cycles + 32'd1;
      // Only WAIT can consume a completion.
      if (mem_resp_valid && state != WAIT)
        spurious <= spurious + 32'd1;
      unique case (state)
        IDLE: begin
          if (grant[1]) begin
            state     <= ISSUE;
            mem_valid <= 1'b1;
            owner     <= REQ_D;
            mem_write <= d_req_write;
            mem_addr  <= d_req_addr;
            mem_data  <= d_req_data;
            d_grants  <= d_grants + 32'd1;
          end else if (grant[0]) begin
            state     <= ISSUE;
            mem_valid <= 1'b1;
            owner     <= REQ_I;
            mem_write <= 1'b0;
            mem_addr  <= i_req_addr;
            mem_data  <= '0;
            i_grants  <= i_grants + 32'd1;
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            if (owner == REQ_D) begin
              d_resp_valid <= 1'b1;
              d_resp_data  <= mem_resp_data;
            end else begin
              i_resp_valid <= 1'b1;
              i_resp_data  <= mem_resp_data;
            end
            last  <= owner;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (report)
      $display("core %0d: i_grants=%0d d_grants=%0d conflict_cycles=%0d spurious=%0d",
               CORE, i_grants, d_grants, conflict_cycles, spurious);
  end
`endif

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Randomised and directed bench for core_mem_arbiter against a
// transaction-level reference model.
module tb_core_mem_arbiter;
  import arbiter_pkg::*;

  localparam int DW = 32;
  localparam int AW = 20;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          iv;
  logic [AW-1:0] ia;
  logic          dv;
  logic          dw;
  logic [AW-1:0] da;
  logic [DW-1:0] dd;
  logic          mr;
  logic          mrv;
  logic [DW-1:0] mrd;
  logic          rpt;

  logic          i_req_ready;
  logic          i_resp_valid;
  logic [DW-1:0] i_resp_data;
  logic          d_req_ready;
  logic          d_resp_valid;
  logic [DW-1:0] d_resp_data;
  logic          mem_valid;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;

  core_mem_arbiter #(.CORE(3), .DATA_WIDTH(DW), .ADDRESS_BITS(AW)) dut (
    .clock          (clock),
    .reset          (reset),
    .i_req_valid    (iv),
    .i_req_addr     (ia),
    .i_req_ready    (i_req_ready),
    .i_resp_valid   (i_resp_valid),
    .i_resp_data    (i_resp_data),
    .d_req_valid    (dv),
    .d_req_write    (dw),
    .d_req_addr     (da),
    .d_req_data     (dd),
    .d_req_ready    (d_req_ready),
    .d_resp_valid   (d_resp_valid),
    .d_resp_data    (d_resp_data),
    .mem_valid      (mem_valid),
    .mem_write      (mem_write),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_ready      (mr),
    .mem_resp_valid (mrv),
    .mem_resp_data  (mrd),
    .report         (rpt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: one transaction record plus observable results
  bit            m_busy;
  bit            m_sent;
  bit            m_owner;
  bit            m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit            m_write;
  bit            e_iv;
  bit            e_dv;
  logic [DW-1:0] e_id;
  logic [DW-1:0] e_dd;
  int unsigned   c_i, c_d, c_c, c_s;
  int            order[$];

  bit hold_i, hold_d, auto_mem, rand_req;
  int rdy_pct, rsp_pct, stray_pct;
  int cyc;
  int last_resp_cyc;
  int min_gap;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_sent = 0; m_owner = 0; m_last = REQ_I;
    m_write = 0; m_addr = '0; m_data = '0;
    e_iv = 0; e_dv = 0; e_id = '0; e_dd = '0;
    c_i = 0; c_d = 0; c_c = 0; c_s = 0;
  endtask

  task automatic step();
    bit gi;
    bit gd;
    if (auto_mem) begin
      mr  = m_busy && !m_sent && ($urandom_range(99) < rdy_pct);
      mrv = (m_busy && m_sent) ? ($urandom_range(99) < rsp_pct)
                               : ($urandom_range(99) < stray_pct);
      mrd = $urandom;
    end
    #1;
    gd = 0;
    gi = 0;
    if (!reset && !m_busy) begin
      gd = dv && (!iv || m_last == REQ_I);
      gi = iv && !gd;
    end
    chk("i_req_ready", i_req_ready, gi);
    chk("d_req_ready", d_req_ready, gd);
    chk("mem_valid", mem_valid, m_busy && !m_sent);
    if (m_busy && !m_sent) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_data", mem_data, m_data);
      chk("mem_write", mem_write, m_write);
    end
    chk("i_resp_valid", i_resp_valid, e_iv);
    chk("d_resp_valid", d_resp_valid, e_dv);
    chk("i_resp_data", i_resp_data, e_id);
    chk("d_resp_data", d_resp_data, e_dd);
    chk("i_grants", dut.i_grants, c_i);
    chk("d_grants", dut.d_grants, c_d);
    chk("conflict_cycles", dut.conflict_cycles, c_c);
    chk("spurious", dut.spurious, c_s);
    if (i_resp_valid || d_resp_valid) begin
      if (last_resp_cyc >= 0 && cyc - last_resp_cyc < min_gap)
        min_gap = cyc - last_resp_cyc;
      last_resp_cyc = cyc;
    end
    if (reset) begin
      model_reset();
    end else begin
      e_iv = 0;
      e_dv = 0;
      if (!m_busy && iv && dv) c_c++;
      if (mrv && !(m_busy && m_sent)) c_s++;
      if (gi || gd) begin
        m_busy  = 1;
        m_sent  = 0;
        m_owner = gd;
        m_addr  = gd ? da : ia;
        m_data  = gd ? dd : '0;
        m_write = gd && dw;
        if (gd) c_d++; else c_i++;
        order.push_back(int'(gd));
      end else if (m_busy && !m_sent) begin
        if (mr) m_sent = 1;
      end else if (m_busy && mrv) begin
        m_busy = 0;
        if (m_owner) begin e_dv = 1; e_dd = mrd; end
        else begin e_iv = 1; e_id = mrd; end
        m_last = m_owner;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    if (gi && !hold_i) iv = 0;
    if (gd && !hold_d) dv = 0;
    if (rand_req) begin
      reset = ($urandom_range(499) == 0);
      if (!iv && $urandom_range(99) < 40) begin
        iv = 1; ia = AW'($urandom);
      end
      if (!dv && $urandom_range(99) < 40) begin
        dv = 1; dw = 1'($urandom); da = AW'($urandom); dd = $urandom;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1; iv = 0; dv = 0; dw = 0; mr = 0; mrv = 0; rpt = 0;
    hold_i = 0; hold_d = 0; auto_mem = 0; rand_req = 0;
    step();
    reset = 0;
  endtask

  int exp_order[6];

  initial begin
    reset = 1; iv = 0; ia = '0; dv = 0; dw = 0; da = '0; dd = '0;
    mr = 0; mrv = 0; mrd = '0; rpt = 0;
    hold_i = 0; hold_d = 0; auto_mem = 0; rand_req = 0;
    rdy_pct = 100; rsp_pct = 100; stray_pct = 0;
    cyc = 0; last_resp_cyc = -1; min_gap = 1000;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    do_reset();
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_i_resp_data", i_resp_data, 0);
    chk("rst_spurious", dut.spurious, 0);

    // Lone fetch, minimum latency
    order.delete();
    iv = 1; ia = 20'h00010;
    step();
    chk("fetch_mem_valid", mem_valid, 1);
    chk("fetch_mem_addr", mem_addr, 20'h00010);
    mr = 1;
    step();
    mr = 0; mrv = 1; mrd = 32'h00000013;
    step();
    mrv = 0;
    chk("fetch_resp_valid", i_resp_valid, 1);
    chk("fetch_resp_data", i_resp_data, 32'h00000013);
    chk("fetch_no_d_resp", d_resp_valid, 0);
    step();
    chk("fetch_resp_pulse", i_resp_valid, 0);

    // Conflict from reset: data first, then fetch
    do_reset();
    order.delete();
    rdy_pct = 100; rsp_pct = 100; stray_pct = 0;
    dv = 1; dw = 0; da = 20'h00100; iv = 1; ia = 20'h00004;
    auto_mem = 1;
    repeat (10) step();
    auto_mem = 0; mr = 0; mrv = 0;
    chk("conflict_n_grants", order.size(), 2);
    if (order.size() >= 2) begin
      chk("conflict_first", order[0], 1);
      chk("conflict_second", order[1], 0);
    end
    chk("conflict_cycles_lit", dut.conflict_cycles, 1);
    chk("conflict_i_grants", dut.i_grants, 1);
    chk("conflict_d_grants", dut.d_grants, 1);

    // Store with delayed mem_ready
    do_reset();
    dv = 1; dw = 1; da = 20'h00200; dd = 32'hDEADBEEF;
    step();
    repeat (3) begin
      chk("store_hold_valid", mem_valid, 1);
      chk("store_hold_write", mem_write, 1);
      chk("store_hold_data", mem_data, 32'hDEADBEEF);
      step();
    end
    chk("store_hold_addr", mem_addr, 20'h00200);
    mr = 1;
    step();
    mr = 0;
    chk("store_valid_drop", mem_valid, 0);
    mrv = 1; mrd = 32'h0;
    step();
    mrv = 0;
    chk("store_ack", d_resp_valid, 1);
    chk("store_no_i_resp", i_resp_valid, 0);
    step();
    chk("store_ack_pulse", d_resp_valid, 0);

    // Back-to-back alternation with both held valid
    do_reset();
    order.delete();
    hold_i = 1; hold_d = 1;
    iv = 1; ia = 20'h00040; dv = 1; dw = 0; da = 20'h00080;
    auto_mem = 1; rdy_pct = 100; rsp_pct = 100; stray_pct = 0;
    last_resp_cyc = -1; min_gap = 1000;
    for (int n = 0; n < 40 && order.size() < 6; n++) step();
    iv = 0; dv = 0; hold_i = 0; hold_d = 0;
    repeat (6) step();
    exp_order = '{1, 0, 1, 0, 1, 0};
    chk("b2b_n_grants", order.size() >= 6, 1);
    for (int k = 0; k < 6; k++)
      if (k < order.size()) chk("b2b_order", order[k], exp_order[k]);
    chk("b2b_min_gap_ge3", min_gap >= 3, 1);

    // Reset while waiting for the completion
    do_reset();
    dv = 1; dw = 0; da = 20'h00300;
    step();
    mr = 1;
    step();
    mr = 0;
    reset = 1;
    step();
    reset = 0; mrv = 1; mrd = 32'h55;
    step();
    mrv = 0;
    chk("wrst_no_d_resp", d_resp_valid, 0);
    chk("wrst_spurious", dut.spurious, 1);
    step();
    chk("wrst_still_none", d_resp_valid, 0);
    dv = 1; da = 20'h00304;
    auto_mem = 1;
    repeat (5) step();
    auto_mem = 0; mr = 0; mrv = 0;
    chk("wrst_next_served", dut.d_grants, 1);

    // Stray completion in IDLE with report
    do_reset();
    mrv = 1; rpt = 1; mrd = 32'hABCD;
    step();
    mrv = 0; rpt = 0;
    chk("stray_no_i_resp", i_resp_valid, 0);
    chk("stray_no_d_resp", d_resp_valid, 0);
    chk("stray_spurious", dut.spurious, 1);
    step();

    // Randomised traffic
    do_reset();
    rand_req = 1; auto_mem = 1;
    rdy_pct = 50; rsp_pct = 40; stray_pct = 3;
    repeat (3000) step();
    rand_req = 0; reset = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/core_mem_arbiter.md
CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 Parameters SHALL be: CORE, default 0, core index used in report output; DATA_WIDTH, default 32, data bus width; ADDRESS_BITS, default 20, address width.
REQ-002 clock  input  1  single clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 i_req_valid  input  1  fetch-side request present (read only).
REQ-005 i_req_addr  input  ADDRESS_BITS  fetch address.
REQ-006 i_req_ready  output  1  fetch request accepted this cycle.
REQ-007 i_resp_valid, i_resp_data  output  1, DATA_WIDTH  fetch response strobe and instruction word.
REQ-008 d_req_valid, d_req_write  input  1, 1  data-side request present; 1 means store, 0 means load.
REQ-009 d_req_addr, d_req_data  input  ADDRESS_BITS, DATA_WIDTH  data address and store data.
REQ-010 d_req_ready  output  1  data request accepted this cycle.
REQ-011 d_resp_valid, d_resp_data  output  1, DATA_WIDTH  data response strobe (load data, or an ack for a store) and its data.
REQ-012 mem_valid, mem_write, mem_addr, mem_data  output  1, 1, ADDRESS_BITS, DATA_WIDTH  shared memory request.
REQ-013 mem_ready  input  1  memory accepts the request while mem_valid is high.
REQ-014 mem_resp_valid, mem_resp_data  input  1, DATA_WIDTH  memory completion strobe and read data; a completion is returned for every request, stores included.
REQ-015 report  input  1  performance-report strobe.

Function
REQ-016 The FSM SHALL have three states: IDLE, ISSUE and WAIT; at most one transaction is outstanding at a time.
REQ-017 IDLE: if any req_valid is high, grant the winner; the winner's req_ready is asserted combinationally in the same cycle; latch its addr, data and write (write forced to 0 for fetch) plus the owner ID; go to ISSUE.
REQ-018 Arbitration SHALL be round-robin: when both requesters are valid, grant the side not granted last; after reset the data side has priority.
REQ-019 A lone valid requester SHALL be granted regardless of round-robin state; the loser's req_ready stays 0.
REQ-020 ISSUE: mem_valid=1 with the latched fields held stable until mem_ready; on mem_ready go to WAIT; mem_valid deasserts the following cycle.
REQ-021 WAIT: on mem_resp_valid, register the owner's resp_valid=1 and resp_data=mem_resp_data (valid the next cycle, for one cycle); update last-grant; go to IDLE.
REQ-022 req_ready SHALL be 0 in ISSUE and WAIT; a new grant is possible in the first IDLE cycle, which is the cycle resp_valid is high.
REQ-023 Minimum latency: accept at T, mem_valid at T+1; with mem_ready at T+1 and mem_resp_valid at T+2, resp_valid is high at T+3.
REQ-024 mem_resp_valid in IDLE or ISSUE SHALL be ignored and SHALL increment the spurious counter.
REQ-025 The non-owner resp_valid SHALL never be asserted; resp_data SHALL hold its last value when resp_valid=0.
REQ-026 There SHALL be 32-bit wrapping counters: i_grants, d_grants, conflict_cycles (IDLE with both requests valid) and spurious.
REQ-027 When report=1, the block SHALL $display CORE and all four counters once per asserted cycle.

Reset
REQ-028 On reset: state=IDLE; last-grant=fetch (so data wins first); all counters=0; all outputs=0; any in-flight transaction is dropped without a response.
REQ-029 A mem_resp_valid arriving after a mid-transaction reset SHALL be treated as spurious.

Structure
REQ-030 The state encoding (IDLE/ISSUE/WAIT) and the requester IDs (REQ_I=0, REQ_D=1) SHALL live in a shared package, arbiter_pkg.
REQ-031 The round-robin grant logic SHALL be one sub-module, rr_arbiter2: inputs req[1:0] and last; output grant[1:0], one-hot or zero.

Verification
REQ-032 Lone fetch: i_req_valid=1, addr 0x00010; mem_ready immediate, resp 0x00000013 next cycle -> i_resp_valid at T+3 with data 0x00000013; d_resp_valid stays 0.
REQ-033 Conflict: both requesters valid from reset (d addr 0x00100, i addr 0x00004) -> d granted first, i second; conflict_cycles=1 and each grant counter=1.
REQ-034 Store: d_req_write=1, addr 0x00200, data 0xDEADBEEF -> mem_write=1 and mem_data=0xDEADBEEF held until mem_ready, which is delayed 3 cycles; then a d_resp_valid pulse.
REQ-035 Back-to-back: both requesters held valid for 6 transactions -> grant order d,i,d,i,d,i; resp_valid pulses separated by at least 3 cycles.
REQ-036 Reset asserted in WAIT, then mem_resp_valid -> no resp_valid; spurious=1; next request served normally.
REQ-037 Stray mem_resp_valid in IDLE -> no response outputs; spurious increments; report=1 prints counters.
